// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM,
// with a bounded grant lock for atomic sequences and read-data routing.
module ram_arbiter #(
  parameter int AW       = 17,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_lock,
  input  logic [3:0]       m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_lock,
  input  logic [3:0]       m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             ram_ce,
  output logic [3:0]       ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {LK_NONE, LK_M0, LK_M1} lock_t;

  lock_t            lock_q, lock_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             last_q, last_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_id_q, rd_id_d;
  logic [CNT_W-1:0] conf_q, conf_d;

  logic             g0, g1;
  logic [3:0]       sel_we;
  logic             sel_lock;
  logic [LCW-1:0]   cnt_inc;
  logic             lost;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (lock_q == LK_M0 && m0_req)      g0 = 1'b1;
    else if (lock_q == LK_M1 && m1_req) g1 = 1'b1;
    else if (m0_req && m1_req) begin
      if (last_q) g0 = 1'b1;
      else        g1 = 1'b1;
    end
    else if (m0_req) g0 = 1'b1;
    else if (m1_req) g1 = 1'b1;
    // Combinational grant path is forced quiet while reset is asserted.
    g0 = g0 & ~rst;
    g1 = g1 & ~rst;
  end

  always_comb begin
    sel_we   = g1 ? m1_we   : m0_we;
    sel_lock = g1 ? m1_lock : m0_lock;
    m0_gnt   = g0;
    m1_gnt   = g1;
    ram_ce   = g0 | g1;
    ram_we   = ram_ce ? sel_we : '0;
    ram_addr = rst ? '0 : (g1 ? m1_addr  : m0_addr);
    ram_din  = rst ? '0 : (g1 ? m1_wdata : m0_wdata);

    m0_rvalid = rd_pend_q & ~rd_id_q;
    m1_rvalid = rd_pend_q &  rd_id_q;
    m0_rdata  = m0_rvalid ? ram_dout : '0;
    m1_rdata  = m1_rvalid ? ram_dout : '0;
    conflict_cnt = conf_q;
  end

  always_comb begin
    last_d     = last_q;
    rd_pend_d  = 1'b0;
    rd_id_d    = rd_id_q;
    lock_d     = LK_NONE;
    lock_cnt_d = '0;
    cnt_inc    = '0;
    if (ram_ce) begin
      last_d    = g1;
      rd_pend_d = (sel_we == 4'b0000);
      rd_id_d   = g1;
      if (sel_lock) begin
        // A fresh lock (new owner) restarts counting from zero.
        if ((g0 && lock_q == LK_M0) || (g1 && lock_q == LK_M1))
          cnt_inc = lock_cnt_q + LCW'(1);
        else
          cnt_inc = LCW'(1);
        if (cnt_inc < LCW'(LOCK_MAX)) begin
          lock_d     = g1 ? LK_M1 : LK_M0;
          lock_cnt_d = cnt_inc;
        end
      end
    end

    lost   = (m0_req & ~g0) | (m1_req & ~g1);
    conf_d = conf_q;
    if (lost && conf_q != '1) conf_d = conf_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= LK_NONE;
      lock_cnt_q <= '0;
      last_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      conf_q     <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      conf_q     <= conf_d;
    end
  end

endmodule
